// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch pipeline.
// Holds the data width, the NOP encoding used for bubbles, and the fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {BOOT, RUN} fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold, bubble and load behaviour.
// A bubble overrides hold; a bubble keeps the previous pc fields.
module ifid_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pcplus4,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcplus4,
  output logic            id_valid
);

  logic [XLEN-1:0] instr_q, pc_q, pcplus4_q;
  logic            valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP;
      pc_q      <= RESET_PC;
      pcplus4_q <= RESET_PC + 32'd4;
      valid_q   <= 1'b0;
    end else if (bubble) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (!hold) begin
      instr_q   <= instr;
      pc_q      <= pc;
      pcplus4_q <= pcplus4;
      valid_q   <= 1'b1;
    end
  end

  assign id_instr   = instr_q;
  assign id_pc      = pc_q;
  assign id_pcplus4 = pcplus4_q;
  assign id_valid   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, boot counter/FSM and the IF/ID register.
// Define FETCH_MISALIGN_DETECT_EN to add a sticky misaligned-redirect flag output.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     BOOT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcplus4,
  output logic            id_valid
`ifdef FETCH_MISALIGN_DETECT_EN
  ,
  output logic            misalign
`endif
);

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  fetch_state_t    state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic            ifid_hold, ifid_bubble;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    ifid_hold   = 1'b1;
    ifid_bubble = 1'b0;
    case (state_q)
      BOOT: begin
        // IF/ID already holds the reset bubble, so holding it keeps the bubble.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == BootLast) state_d = RUN;
      end
      RUN: begin
        if (pcsrc)       pc_d = {branch_target[XLEN-1:2], 2'b00};
        else if (!stall) pc_d = pc_plus4;
        ifid_bubble = pcsrc | flush;
        ifid_hold   = stall;
      end
      default: state_d = BOOT;
    endcase
  end

  ifid_reg #(
    .RESET_PC (RESET_PC)
  ) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .hold       (ifid_hold),
    .bubble     (ifid_bubble),
    .instr      (imem_instr),
    .pc         (pc_q),
    .pcplus4    (pc_plus4),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pcplus4 (id_pcplus4),
    .id_valid   (id_valid)
  );

`ifdef FETCH_MISALIGN_DETECT_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (state_q == RUN && pcsrc && (branch_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign = misalign_q;
`else
  // Low target bits are dropped silently when detection is not built in.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target[1:0];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with default parameters.
// Instruction memory returns addr ^ 32'hDEAD_0000 so fetched words identify their address.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;
  logic        id_valid;
`ifdef FETCH_MISALIGN_DETECT_EN
  logic        misalign;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pcplus4    (id_pcplus4),
    .id_valid      (id_valid)
`ifdef FETCH_MISALIGN_DETECT_EN
    ,
    .misalign      (misalign)
`endif
  );

  assign imem_instr = imem_addr ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_id(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic vld);
    chk({tag, ".instr"}, id_instr, ins);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".pcplus4"}, id_pcplus4, pc4);
    chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    pcsrc = 1'b0;
    branch_target = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.addr", imem_addr, 32'h0);
    chk_id("rst", Nop, 32'h0, 32'h4, 1'b0);
`ifdef FETCH_MISALIGN_DETECT_EN
    chk("rst.misalign", {31'd0, misalign}, 32'd0);
`endif

    // Boot: three cycles at PC 0 with no valid instruction; redirects ignored.
    rst = 1'b0;
    chk("boot0.addr", imem_addr, 32'h0);
    chk("boot0.valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("boot1.addr", imem_addr, 32'h0);
    chk("boot1.valid", {31'd0, id_valid}, 32'd0);
    pcsrc = 1'b1;
    flush = 1'b1;
    branch_target = 32'h100;
    step();
    chk("boot2.addr", imem_addr, 32'h0);
    chk_id("boot2", Nop, 32'h0, 32'h4, 1'b0);
    pcsrc = 1'b0;
    flush = 1'b0;
    step();
    chk("run0.addr", imem_addr, 32'h4);
    chk_id("run0", 32'hDEAD_0000, 32'h0, 32'h4, 1'b1);
    step();
    chk("run1.addr", imem_addr, 32'h8);
    chk_id("run1", 32'hDEAD_0004, 32'h4, 32'h8, 1'b1);
    step();
    chk("run2.addr", imem_addr, 32'hC);
    chk_id("run2", 32'hDEAD_0008, 32'h8, 32'hC, 1'b1);
    step();
    chk("run3.addr", imem_addr, 32'h10);

    // Taken branch at PC 0x10 to 0x40.
    pcsrc = 1'b1;
    branch_target = 32'h40;
    step();
    chk("br.addr", imem_addr, 32'h40);
    chk_id("br.bubble", Nop, 32'hC, 32'h10, 1'b0);
    pcsrc = 1'b0;
    step();
    chk("br1.addr", imem_addr, 32'h44);
    chk_id("br1", 32'hDEAD_0040, 32'h40, 32'h44, 1'b1);

    // Redirect to 0x1C so a valid instruction sits in IF/ID while PC = 0x20 stalls.
    pcsrc = 1'b1;
    branch_target = 32'h1C;
    step();
    pcsrc = 1'b0;
    step();
    chk("pre_stall.addr", imem_addr, 32'h20);
    chk_id("pre_stall", 32'hDEAD_001C, 32'h1C, 32'h20, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.addr", imem_addr, 32'h20);
      chk_id("stall", 32'hDEAD_001C, 32'h1C, 32'h20, 1'b1);
    end
    stall = 1'b0;
    step();
    chk("unstall.addr", imem_addr, 32'h24);
    chk_id("unstall", 32'hDEAD_0020, 32'h20, 32'h24, 1'b1);

    // Redirect wins over stall and bubbles IF/ID on the same edge.
    stall = 1'b1;
    pcsrc = 1'b1;
    branch_target = 32'h80;
    step();
    chk("stbr.addr", imem_addr, 32'h80);
    chk_id("stbr", Nop, 32'h20, 32'h24, 1'b0);
    stall = 1'b0;
    pcsrc = 1'b0;

    // Flush alone: PC advances, IF/ID bubbles.
    flush = 1'b1;
    step();
    chk("flush.addr", imem_addr, 32'h84);
    chk_id("flush", Nop, 32'h20, 32'h24, 1'b0);
    flush = 1'b0;
    step();
    chk("postflush.addr", imem_addr, 32'h88);
    chk_id("postflush", 32'hDEAD_0084, 32'h84, 32'h88, 1'b1);

    // PC wrap at the top of the address space.
    pcsrc = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    chk("top.addr", imem_addr, 32'hFFFF_FFFC);
    pcsrc = 1'b0;
    step();
    chk("wrap.addr", imem_addr, 32'h0);
    chk_id("wrap", 32'h2152_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Misaligned target is aligned down.
    pcsrc = 1'b1;
    branch_target = 32'h42;
    step();
    chk("mis.addr", imem_addr, 32'h40);
`ifdef FETCH_MISALIGN_DETECT_EN
    chk("mis.flag", {31'd0, misalign}, 32'd1);
`endif
    pcsrc = 1'b0;
    step();
    chk("mis1.addr", imem_addr, 32'h44);
`ifdef FETCH_MISALIGN_DETECT_EN
    chk("mis1.flag", {31'd0, misalign}, 32'd1);
`endif

    // Asynchronous reset mid-stall, between clock edges.
    stall = 1'b1;
    step();
    chk("prerst.addr", imem_addr, 32'h44);
    #2 rst = 1'b1;
    #1;
    chk("arst.addr", imem_addr, 32'h0);
    chk_id("arst", Nop, 32'h0, 32'h4, 1'b0);
`ifdef FETCH_MISALIGN_DETECT_EN
    chk("arst.misalign", {31'd0, misalign}, 32'd0);
`endif
    step();
    rst = 1'b0;
    stall = 1'b0;
    chk("reboot0.addr", imem_addr, 32'h0);
    step();
    chk("reboot1.valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("reboot2.addr", imem_addr, 32'h0);
    chk("reboot2.valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("reboot3.addr", imem_addr, 32'h4);
    chk_id("reboot3", 32'hDEAD_0000, 32'h0, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the program counter value loaded on reset.
REQ-002 Parameter BOOT_CYCLES, default 2, range 1..15, SHALL be the number of post-reset cycles before fetching starts.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 stall  in  1  SHALL hold the PC and the IF/ID register.
REQ-006 flush  in  1  SHALL insert a bubble into the IF/ID register.
REQ-007 pcsrc  in  1  SHALL redirect fetch to branch_target (taken branch or jump).
REQ-008 branch_target  in  32  SHALL be the redirect address (PC + immop from execute).
REQ-009 imem_addr  out  32  SHALL be the current PC presented to instruction memory.
REQ-010 imem_instr  in  32  SHALL be combinational read data for imem_addr.
REQ-011 id_instr  out  32  SHALL be the registered instruction for decode and the sign extender.
REQ-012 id_pc  out  32  SHALL be the registered PC of id_instr.
REQ-013 id_pcplus4  out  32  SHALL be the registered id_pc + 4.
REQ-014 id_valid  out  1  SHALL be high when id_instr is a real fetched instruction.

Function
REQ-015 States BOOT, RUN; BOOT SHALL be entered on reset; BOOT->RUN after BOOT_CYCLES cycles counted by a 4-bit counter; RUN SHALL persist until reset.
REQ-016 In BOOT: PC SHALL hold RESET_PC, IF/ID SHALL hold the bubble, and stall/flush/pcsrc SHALL be ignored.
REQ-017 In RUN, the next PC SHALL be, in priority order: pcsrc -> {branch_target[31:2],2'b00}; stall -> PC; else -> PC + 4.
REQ-018 PC + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 In RUN, if pcsrc or flush, IF/ID SHALL load the bubble: id_instr = 32'h0000_0013 (NOP), id_valid = 0, id_pc/id_pcplus4 unchanged.
REQ-020 Otherwise, if stall, IF/ID SHALL hold all fields.
REQ-021 Otherwise, IF/ID SHALL load imem_instr, PC and PC+4, and set id_valid = 1.
REQ-022 pcsrc with stall SHALL redirect the PC and flush IF/ID; the redirect is never lost.
REQ-023 imem_addr SHALL equal the PC register combinationally, with zero added latency.
REQ-024 Fetch-to-decode latency SHALL be one cycle: an instruction at imem_addr in cycle N appears on id_instr in cycle N+1.

Reset
REQ-025 While rst is high, PC = RESET_PC, state = BOOT, counter = 0, id_instr = 32'h0000_0013, id_pc = RESET_PC, id_pcplus4 = RESET_PC + 4, id_valid = 0; all take effect immediately, independent of clk.
REQ-026 Reset asserted mid-operation SHALL abandon any pending redirect or stall; fetch SHALL restart from RESET_PC after BOOT.

Configuration
REQ-027 With macro FETCH_MISALIGN_DETECT_EN defined, output port misalign (1 bit) SHALL exist; it SHALL be set on a RUN-state pcsrc with branch_target[1:0] != 0, SHALL stay set until reset, and SHALL reset to 0.
REQ-028 Without FETCH_MISALIGN_DETECT_EN, the misalign port and its register SHALL be absent; the target SHALL still be silently aligned per REQ-017.

Structure
REQ-029 Package riscv_pkg SHALL hold XLEN = 32, the NOP constant 32'h0000_0013, and the fetch_state_t enum {BOOT, RUN}.
REQ-030 The IF/ID register (hold, bubble and load behaviour) SHALL be a sub-module named ifid_reg; the PC, counter and FSM SHALL stay in fetch_stage.

Verification
REQ-031 Reset, release, BOOT_CYCLES = 2 -> imem_addr = 0 for 3 cycles, id_valid = 0 for the first 3 cycles, then PCs 0, 4, 8 appear on id_pc with id_valid = 1.
REQ-032 In RUN at PC = 32'h10, pcsrc = 1, branch_target = 32'h40 -> next imem_addr = 32'h40, id_instr = NOP, id_valid = 0 for one cycle, then id_pc = 32'h40.
REQ-033 stall held 3 cycles at PC = 32'h20 -> imem_addr stays 32'h20 and the IF/ID fields are unchanged; on release, PC = 32'h24 on the next edge.
REQ-034 stall = 1 and pcsrc = 1 with branch_target = 32'h80 -> PC = 32'h80 and IF/ID bubbled on the same edge.
REQ-035 PC = 32'hFFFF_FFFC, no stall -> next PC = 32'h0; with the macro, pcsrc with branch_target = 32'h42 -> PC = 32'h40 and misalign = 1 sticky until rst.
REQ-036 rst pulsed asynchronously between clock edges mid-stall -> all outputs take reset values before the next edge and BOOT restarts.
